multiplier_arbiter: RTL
=======================

// Module: multiplier_arbiter
// PURPOSE
//  Shares one sequential Multiplier instance among NUM_REQ requesters with round-robin arbitration.
//  Each accepted job runs the multiplier's required sequence: reset, start pulse, fixed-latency wait,
//  product capture. The result goes back on a valid/ready response channel tagged with the requester id.
//  Sits between client blocks and the Multiplier; it is the only driver of the Multiplier's ports.
// PARAMETERS
//  NUM_BITS     7              operand width; product width is 2*NUM_BITS
//  NUM_REQ      4              number of requesters, >=2
//  MUL_LATENCY  2*NUM_BITS+2   WAIT cycles after the start pulse before product is valid; >=1
//  ID_W         $clog2(NUM_REQ) localparam, requester id width
// PORTS
//  clk               in   1                   clock, rising edge
//  rst               in   1                   synchronous, active-low reset (0 = reset)
//  req_valid         in   NUM_REQ             per-requester job valid
//  req_ready         out  NUM_REQ             per-requester accept; at most one bit set
//  req_multiplier    in   NUM_REQ*NUM_BITS    packed operands; slice i = [i*NUM_BITS +: NUM_BITS]
//  req_multiplicand  in   NUM_REQ*NUM_BITS    packed operands, same packing
//  resp_valid        out  1                   result available
//  resp_ready        in   1                   consumer accepts result
//  resp_id           out  ID_W                index of the requester that owns the result
//  resp_product      out  2*NUM_BITS          multiplier*multiplicand
//  mul_rst           out  1                   active-high reset to the Multiplier
//  mul_start         out  1                   start pulse to the Multiplier
//  mul_multiplier    out  NUM_BITS            operand to the Multiplier, stable START..WAIT
//  mul_multiplicand  out  NUM_BITS            operand to the Multiplier, stable START..WAIT
//  mul_product       in   2*NUM_BITS          product from the Multiplier
//  busy              out  1                   1 in any state other than IDLE
// BEHAVIOUR
//  Reset (rst==0 at a rising edge):
//   - state goes to IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority.
//   - resp_valid=0, resp_id=0, resp_product=0, mul_start=0, latched operands=0.
//   - mul_rst = ~rst | (state==CLEAR), so the Multiplier is held in reset while rst is low.
//   - Reset mid-job abandons the job silently; no response is produced for it.
//  States: IDLE -> CLEAR -> START -> WAIT -> RESP -> IDLE.
//   IDLE : grant = first i with req_valid[i], searching from ptr+1 upward with wrap-around.
//          req_ready[grant] = 1, combinational, only in IDLE.
//          On req_valid&req_ready: latch operands and id, set ptr = grant, go to CLEAR.
//          With no valid requests, stay in IDLE.
//   CLEAR: mul_rst=1 for exactly one cycle; go to START.
//   START: mul_start=1 for exactly one cycle; go to WAIT; load counter = MUL_LATENCY-1.
//   WAIT : decrement the counter. When it is 0: capture resp_product <= mul_product and
//          resp_id <= latched id, set resp_valid=1, go to RESP.
//   RESP : hold resp_valid and data stable until resp_ready==1; on that handshake,
//          clear resp_valid and return to IDLE.
//          resp_ready is ignored whenever resp_valid==0.
//  Latency: job accepted in cycle t -> resp_valid is first high in cycle t+3+MUL_LATENCY.
//  Throughput: at most one job per 4+MUL_LATENCY cycles; the IDLE cycle is never skipped.
//  Fairness: a requester that stays valid is served within NUM_REQ jobs.
//   A requester may drop req_valid while not granted; it is not a violation.
//  Operands: mul_multiplier and mul_multiplicand are driven from the latched registers in all states.
//  resp_product width is 2*NUM_BITS; no truncation and no saturation.
//  Zero operands take the full latency; there is no shortcut.
// STRUCTURE
//  Shared header mul_arb_defs.vh holds:
//   - state encodings S_IDLE..S_RESP (3-bit)
//   - the default MUL_LATENCY expression
//  Sub-module rr_picker (combinational, NUM_REQ parameter):
//   - inputs req, ptr; outputs one-hot grant and grant index
//  The top level holds the FSM, the latency counter, operand/id latches and the response registers.
//  The bench instantiates the top level together with Multiplier #(NUM_BITS).
// TESTING
//  1. rst=0 for 2 clk -> req_ready=0, resp_valid=0, busy=0, mul_rst=1; after release mul_rst=0.
//  2. Single job: req0 with 15 x 15, resp_ready=1 -> resp_valid at t+3+MUL_LATENCY,
//     resp_id=0, resp_product=225.
//  3. All four valid at once: 92x75, 0x12, 1x2, 0x0 -> ids in order 0,1,2,3;
//     products 6900, 0, 2, 0.
//  4. Backpressure: resp_ready=0 for 10 cycles -> resp_valid and data stay stable,
//     busy=1, no new req_ready; one cycle after the handshake, state is IDLE.
//  5. Wrap-around: after serving req3, req3 and req0 are both valid -> req0 is granted first.
//  6. rst=0 during WAIT -> next cycle IDLE, no response; a new job for 127x127
//     then returns 16129.

Source files
------------

// File: rtl/multiplier_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM states and default latency.
package multiplier_arbiter_pkg;

  // Job sequence: arbitrate, reset multiplier, start pulse, wait, hand back result
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  // Cycles the sequential multiplier needs after its start pulse
  function automatic int unsigned mul_latency_default(input int unsigned num_bits);
    return 2 * num_bits + 2;
  endfunction

endpackage

// File: rtl/multiplier_arbiter_rr_picker.sv
// Round-robin picker: first set request strictly after ptr, wrapping around.
module rr_picker #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [ID_W-1:0]    grant_idx_c,
  output logic               valid_c
);

  logic [ID_W-1:0] idx;

  // Scan ptr+1 .. ptr+NUM_REQ; the previous winner is checked last
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    valid_c     = 1'b0;
    idx         = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!valid_c && req[idx]) begin
        valid_c      = 1'b1;
        grant_c[idx] = 1'b1;
        grant_idx_c  = idx;
      end
    end
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one sequential multiplier among NUM_REQ requesters, round-robin,
// returning each product on a valid/ready channel tagged with the requester id.
module multiplier_arbiter
  import multiplier_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_BITS    = 7,
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned MUL_LATENCY = mul_latency_default(NUM_BITS),
  localparam int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_multiplier,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_multiplicand,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [2*NUM_BITS-1:0]        resp_product,
  output logic                         mul_rst,
  output logic                         mul_start,
  output logic [NUM_BITS-1:0]          mul_multiplier,
  output logic [NUM_BITS-1:0]          mul_multiplicand,
  input  logic [2*NUM_BITS-1:0]        mul_product,
  output logic                         busy
);

  localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 1);

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_BITS-1:0] op_a_q;
  logic [NUM_BITS-1:0] op_b_q;

  logic [NUM_REQ-1:0]  grant_c;
  logic [ID_W-1:0]     grant_idx_c;
  logic                grant_valid_c;
  logic [NUM_BITS-1:0] sel_a_c;
  logic [NUM_BITS-1:0] sel_b_c;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req         (req_valid),
    .ptr         (ptr_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .valid_c     (grant_valid_c)
  );

  // Operand mux for the granted requester
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_c == ID_W'(i)) begin
        sel_a_c = req_multiplier[i*NUM_BITS +: NUM_BITS];
        sel_b_c = req_multiplicand[i*NUM_BITS +: NUM_BITS];
      end
    end
  end

  // Accept only in IDLE and never while reset is asserted
  assign req_ready        = (rst && (state_q == S_IDLE)) ? grant_c : '0;
  // Multiplier is held in reset with the arbiter and pulsed once per job
  assign mul_rst          = ~rst | (state_q == S_CLEAR);
  assign mul_multiplier   = op_a_q;
  assign mul_multiplicand = op_b_q;
  assign busy             = (state_q != S_IDLE);

  // Job FSM with latency counter, operand/id latches and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_product <= '0;
      mul_start    <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_valid_c) begin
            op_a_q  <= sel_a_c;
            op_b_q  <= sel_b_c;
            id_q    <= grant_idx_c;
            ptr_q   <= grant_idx_c;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          mul_start <= 1'b1;
          state_q   <= S_START;
        end
        S_START: begin
          cnt_q   <= CNT_W'(MUL_LATENCY - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            resp_product <= mul_product;
            resp_id      <= id_q;
            resp_valid   <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
